// File: rtl/ls_order_unit.sv
// Load/store ordering core: issue-order tag FIFO, address adder, and an ordered
// list of address-resolved tags that picks mem_tag. Optional LOAD_BYPASS_EN.
module ls_order_unit #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ORDER_DEPTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   tag_in,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [3:0]   tag_out,
  output logic         lsq_full,
  output logic         lsq_empty,
  input  logic [63:0]  op,
  input  logic [63:0]  offset,
  output logic [63:0]  address,
  input  logic         aff_ready,
  input  logic [4:0]   ready_bus,
  input  logic [319:0] address_bus,
  input  logic         remove,
  output logic [3:0]   mem_tag,
  output logic [2:0]   order_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic tag_ok(input logic [3:0] t);
    return (t >= 4'd6) && (t <= 4'd10);
  endfunction

  function automatic logic [2:0] slot(input logic [3:0] t);
    logic [2:0] s;
    s = 3'd0;
    case (t)
      4'd9:    s = 3'd0;
      4'd10:   s = 3'd1;
      4'd6:    s = 3'd2;
      4'd7:    s = 3'd3;
      4'd8:    s = 3'd4;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic tag_rdy(input logic [3:0] t);
    return tag_ok(t) && ready_bus[slot(t)];
  endfunction

  // ---------------- tag FIFO ----------------
  logic [3:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          do_push, do_pop;

  assign lsq_empty = (fcnt_q == '0);
  assign lsq_full  = (fcnt_q == CW'(FIFO_DEPTH));
  assign tag_out   = lsq_empty ? 4'd0 : fifo_q[rptr_q];

  // A pop frees the slot this edge, so a write while full still lands.
  assign do_pop  = rd_en && !lsq_empty;
  assign do_push = wr_en && tag_ok(tag_in) && (!lsq_full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    fcnt_d = fcnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 4'd0;
    end else if (do_push) begin
      fifo_q[wptr_q] <= tag_in;
    end
  end

  // ---------------- address ----------------
  assign address = op + offset;

  // ---------------- order list ----------------
  logic [3:0] ord_q [ORDER_DEPTH];
  logic [3:0] ord_d [ORDER_DEPTH];
  logic [2:0] ocnt_q, ocnt_d;
  logic [3:0] gnt_tag;
  logic [2:0] gnt_idx;
  logic       present;
  logic       do_app, do_ret;

  always_comb begin
    present = 1'b0;
    for (int i = 0; i < ORDER_DEPTH; i++) begin
      if (i < int'(ocnt_q) && ord_q[i] == tag_out) present = 1'b1;
    end
  end

`ifdef LOAD_BYPASS_EN
  function automatic logic is_load(input logic [3:0] t);
    return (t >= 4'd6) && (t <= 4'd8);
  endfunction

  function automatic logic [63:0] tag_addr(input logic [3:0] t);
    return address_bus[64*int'(slot(t)) +: 64];
  endfunction

  logic stop;
  logic hit;

  // Only the first load can bypass: any later load has an older load ahead.
  always_comb begin
    gnt_tag = 4'd0;
    gnt_idx = 3'd0;
    stop    = 1'b0;
    hit     = 1'b0;
    if (ocnt_q != 3'd0 && tag_rdy(ord_q[0])) begin
      gnt_tag = ord_q[0];
    end else begin
      for (int i = 0; i < ORDER_DEPTH; i++) begin
        if (!stop && i < int'(ocnt_q) && is_load(ord_q[i])) begin
          stop = 1'b1;
          hit  = 1'b0;
          for (int j = 0; j < ORDER_DEPTH; j++) begin
            if (j < i && tag_rdy(ord_q[j]) &&
                tag_addr(ord_q[j]) == tag_addr(ord_q[i]))
              hit = 1'b1;
          end
          if (tag_rdy(ord_q[i]) && !hit) begin
            gnt_tag = ord_q[i];
            gnt_idx = 3'(i);
          end
        end
      end
    end
  end
`else
  logic unused_addr_bus;
  assign unused_addr_bus = ^address_bus;

  always_comb begin
    gnt_tag = 4'd0;
    gnt_idx = 3'd0;
    if (ocnt_q != 3'd0 && tag_rdy(ord_q[0])) gnt_tag = ord_q[0];
  end
`endif

  assign mem_tag     = gnt_tag;
  assign order_count = ocnt_q;

  assign do_ret = remove && (gnt_tag != 4'd0);
  assign do_app = aff_ready && (tag_out != 4'd0) && !present &&
                  (ocnt_q != 3'(ORDER_DEPTH));

  always_comb begin
    for (int i = 0; i < ORDER_DEPTH; i++) ord_d[i] = ord_q[i];
    ocnt_d = ocnt_q;
    if (do_ret) begin
      for (int i = 0; i < ORDER_DEPTH - 1; i++) begin
        if (i >= int'(gnt_idx)) ord_d[i] = ord_q[i+1];
      end
      ord_d[ORDER_DEPTH-1] = 4'd0;
      ocnt_d = ocnt_q - 3'd1;
    end
    if (do_app) begin
      ord_d[ocnt_d] = tag_out;
      ocnt_d = ocnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORDER_DEPTH; i++) ord_q[i] <= 4'd0;
      ocnt_q <= 3'd0;
    end else begin
      for (int i = 0; i < ORDER_DEPTH; i++) ord_q[i] <= ord_d[i];
      ocnt_q <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_ls_order_unit.sv
// Bench for ls_order_unit: directed steps then randomized traffic,
// checked against a queue-based reference model.
module tb_ls_order_unit;

  localparam int FD = 8;
  localparam int OD = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   tag_in;
  logic         wr_en, rd_en;
  logic [3:0]   tag_out;
  logic         lsq_full, lsq_empty;
  logic [63:0]  op, offset, address;
  logic         aff_ready;
  logic [4:0]   ready_bus;
  logic [319:0] address_bus;
  logic         remove;
  logic [3:0]   mem_tag;
  logic [2:0]   order_count;

  int vecs = 0;
  int errs = 0;

  logic [3:0] fq[$];
  logic [3:0] oq[$];

  always #5 clk = ~clk;

  ls_order_unit #(.FIFO_DEPTH(FD), .ORDER_DEPTH(OD)) dut (
    .clk(clk), .rst_n(rst_n),
    .tag_in(tag_in), .wr_en(wr_en), .rd_en(rd_en),
    .tag_out(tag_out), .lsq_full(lsq_full), .lsq_empty(lsq_empty),
    .op(op), .offset(offset), .address(address),
    .aff_ready(aff_ready), .ready_bus(ready_bus),
    .address_bus(address_bus), .remove(remove),
    .mem_tag(mem_tag), .order_count(order_count)
  );

  function automatic int slot_of(input logic [3:0] t);
    case (t)
      4'd9:    return 0;
      4'd10:   return 1;
      4'd6:    return 2;
      4'd7:    return 3;
      4'd8:    return 4;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_rdy(input logic [3:0] t);
    int s;
    s = slot_of(t);
    return (s >= 0) && ready_bus[s];
  endfunction

  function automatic logic [63:0] m_addr(input logic [3:0] t);
    return address_bus[64*slot_of(t) +: 64];
  endfunction

  function automatic logic [3:0] m_tag_out();
    return (fq.size() > 0) ? fq[0] : 4'd0;
  endfunction

  function automatic logic [3:0] m_mem_tag();
    if (oq.size() == 0) return 4'd0;
    if (m_rdy(oq[0])) return oq[0];
`ifdef LOAD_BYPASS_EN
    for (int i = 0; i < oq.size(); i++) begin
      if (oq[i] >= 4'd6 && oq[i] <= 4'd8) begin
        if (!m_rdy(oq[i])) return 4'd0;
        for (int j = 0; j < i; j++)
          if (m_rdy(oq[j]) && m_addr(oq[j]) == m_addr(oq[i])) return 4'd0;
        return oq[i];
      end
    end
`endif
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tag_out", 64'(tag_out), 64'(m_tag_out()));
    chk("lsq_empty", 64'(lsq_empty), 64'(fq.size() == 0));
    chk("lsq_full", 64'(lsq_full), 64'(fq.size() == FD));
    chk("mem_tag", 64'(mem_tag), 64'(m_mem_tag()));
    chk("order_count", 64'(order_count), 64'(oq.size()));
    chk("address", address, op + offset);
  endtask

  task automatic model_update();
    logic [3:0] t, mt;
    bit pop, push, app, ret, dup;
    t   = m_tag_out();
    mt  = m_mem_tag();
    dup = 1'b0;
    foreach (oq[i]) if (oq[i] == t) dup = 1'b1;
    pop  = rd_en && fq.size() > 0;
    push = wr_en && tag_in >= 4'd6 && tag_in <= 4'd10 &&
           (fq.size() < FD || pop);
    app  = aff_ready && t != 4'd0 && !dup && oq.size() < OD;
    ret  = remove && mt != 4'd0;
    if (pop) void'(fq.pop_front());
    if (push) fq.push_back(tag_in);
    if (ret) begin
      for (int i = 0; i < oq.size(); i++) begin
        if (oq[i] == mt) begin
          oq.delete(i);
          break;
        end
      end
    end
    if (app) oq.push_back(t);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; aff_ready = 0; remove = 0;
  endtask

  initial begin
    logic [3:0] fill [8];
    logic [63:0] pick [3];
    fill = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd6, 4'd7, 4'd8};
    pick = '{64'h1000, 64'h2000, 64'h1008};
    rst_n = 1'b1;
    tag_in = 0; idle();
    op = 0; offset = 0; ready_bus = 0; address_bus = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_tag_out", 64'(tag_out), 64'd0);
    chk("rst_mem_tag", 64'(mem_tag), 64'd0);
    chk("rst_empty", 64'(lsq_empty), 64'd1);
    chk("rst_full", 64'(lsq_full), 64'd0);
    chk("rst_count", 64'(order_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 6, 9, 7 then pop them in order
    wr_en = 1; tag_in = 4'd6; tick();
    tag_in = 4'd9; tick();
    tag_in = 4'd7; tick();
    wr_en = 0; rd_en = 1; #1;
    chk("fwft_6", 64'(tag_out), 64'd6);
    tick(); #1 chk("seq_9", 64'(tag_out), 64'd9);
    tick(); #1 chk("seq_7", 64'(tag_out), 64'd7);
    tick(); #1 chk("seq_0", 64'(tag_out), 64'd0);
    rd_en = 0; wr_en = 1; tag_in = 4'd3; tick(); #1;
    chk("bad_tag_dropped", 64'(lsq_empty), 64'd1);
    check_all();

    // Fill, overfill, write+pop while full, drain
    for (int i = 0; i < 8; i++) begin
      tag_in = fill[i]; tick();
    end
    #1 chk("full_after_8", 64'(lsq_full), 64'd1);
    tag_in = 4'd9; tick(); #1 check_all();
    rd_en = 1; tag_in = 4'd10; tick(); #1;
    chk("full_wr_pop", 64'(lsq_full), 64'd1);
    check_all();
    wr_en = 0;
    for (int i = 0; i < 9; i++) begin
      #1 check_all();
      tick();
    end
    idle();

    op = 64'hFFFF_FFFF_FFFF_FFF0; offset = 64'h20; #1;
    chk("addr_wrap", address, 64'h10);

    // Order list: append 9 then 6
    wr_en = 1; tag_in = 4'd9; tick();
    tag_in = 4'd6; tick();
    wr_en = 0; aff_ready = 1; tick();
    aff_ready = 0; rd_en = 1; tick();
    rd_en = 0; aff_ready = 1; tick();
    aff_ready = 0; ready_bus = 5'b00100; #1;
    chk("count_2", 64'(order_count), 64'd2);
`ifdef LOAD_BYPASS_EN
    chk("bypass_ld", 64'(mem_tag), 64'd6);
    address_bus[63:0] = 64'h40; address_bus[191:128] = 64'h40;
`else
    chk("head_not_ready", 64'(mem_tag), 64'd0);
`endif
    ready_bus = 5'b00101; #1;
    chk("head_ready", 64'(mem_tag), 64'd9);
    remove = 1; tick(); remove = 0; #1;
    chk("after_remove", 64'(mem_tag), 64'd6);
    chk("count_1", 64'(order_count), 64'd1);
    remove = 1; tick(); remove = 0; #1;
    check_all();

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 800; c++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      tag_in    = 4'($urandom_range(4, 11));
      rd_en     = ($urandom_range(0, 3) == 0);
      aff_ready = ($urandom_range(0, 1) == 1);
      remove    = ($urandom_range(0, 2) == 0);
      ready_bus = 5'($urandom_range(0, 31));
      for (int s = 0; s < 5; s++)
        address_bus[64*s +: 64] = pick[$urandom_range(0, 2)];
      op     = {$urandom, $urandom};
      offset = {$urandom, $urandom};
      if (c % 199 == 150) begin
        rst_n = 1'b0;
        #1;
        fq.delete();
        oq.delete();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        #1 check_all();
        tick();
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ls_order_unit.md
Name: ls_order_unit

Overview:
Memory-ordering core of the load/store reservation block. It queues load/store tags in issue order in a tag FIFO. It computes effective addresses (base + offset) and keeps an ordered list of address-resolved entries. From that list it selects the single tag allowed to access memory (mem_tag). It sits between the load/store reservation stations and the memory unit/CDB arbiter.

Parameters:
FIFO_DEPTH, 8, tag FIFO entries (power of two, at least 2).
ORDER_DEPTH, 5, order-list entries (one per load/store tag).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
tag_in  input  4  tag to enqueue.
wr_en  input  1  enqueue tag_in.
rd_en  input  1  pop FIFO head.
tag_out  output  4  FIFO head tag; 0 (notag) when empty.
lsq_full  output  1  FIFO full.
lsq_empty  output  1  FIFO empty.
op  input  64  address base operand.
offset  input  64  address offset.
address  output  64  op + offset.
aff_ready  input  1  address of tag_out is resolved this cycle.
ready_bus  input  5  per-tag ready: bit0 st_1, bit1 st_2, bit2 ld_1, bit3 ld_2, bit4 ld_3.
address_bus  input  320  per-tag addresses, 64 bits each, same slot order as ready_bus (st_1 at [63:0] … ld_3 at [319:256]).
remove  input  1  current mem_tag has completed; retire it.
mem_tag  output  4  tag granted to memory; 0 if none.
order_count  output  3  number of entries in the order list.

Behaviour:
- Tag encoding: notag=0, ld_1=6, ld_2=7, ld_3=8, st_1=9, st_2=10. Loads are 6–8; stores are 9–10.
- Any tag outside 6..10 is never written into the FIFO or the order list.
- Reset (async, rst_n=0):
  - FIFO and order list empty.
  - tag_out=0, mem_tag=0, order_count=0, lsq_empty=1, lsq_full=0.
- Tag FIFO:
  - Write on rising clk when wr_en=1, tag valid, and not full. A write while full is dropped.
  - Pop on rising clk when rd_en=1 and not empty. rd_en while empty is a no-op.
  - Simultaneous write and pop while full: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tag_out is the registered head, combinational from state. First-word-fall-through: a tag written into an empty FIFO appears on tag_out the next cycle.
- Address: address = op + offset, purely combinational, modulo 2^64, carry discarded.
- Order list:
  - On rising clk with aff_ready=1 and tag_out!=0, tag_out is appended at the tail.
  - The append is dropped if the list is full or the tag is already present.
- mem_tag (combinational):
  - Equals the order-list head if that tag's ready_bus bit is 1; otherwise 0.
  - Equals 0 when the list is empty.
- Retire: on rising clk with remove=1 and mem_tag!=0, the entry holding mem_tag is removed and younger entries shift toward the head. remove with mem_tag=0 is ignored.
- Append and retire in the same cycle: both take effect, and order_count is unchanged.
- An entry whose ready bit drops is not removed; it simply stops being granted.
- Reset mid-operation discards all queued tags immediately.

Optional Feature:
LOAD_BYPASS_EN.
- When defined: if the head is not granted, mem_tag is the oldest ready load that meets both conditions:
  - every older entry is a store, and
  - no older store is ready with an address equal to that load's address (per address_bus).
  Older stores that are not yet ready do not block the load.
- When undefined: strict in-order grant from the head only.

Test Plan:
- Reset → tag_out=0, mem_tag=0, lsq_empty=1, order_count=0.
- Write 6, 9, 7 on three edges; rd_en=1 each cycle after → tag_out sequence 6, 9, 7, then 0. Write 3 → ignored.
- Fill FIFO with 8 valid tags → lsq_full=1; a 9th write is dropped; write+pop while full keeps count at 8.
- op=64'hFFFF_FFFF_FFFF_FFF0, offset=64'h20 → address=64'h10.
- aff_ready with tag_out=9, then with tag_out=6:
  - ready_bus=5'b00100 → mem_tag=0 (head 9 not ready).
  - ready_bus=5'b00101 → mem_tag=9; remove → mem_tag=6, order_count=1.
- With LOAD_BYPASS_EN, order 9, 6:
  - ready_bus=5'b00100 → mem_tag=6.
  - st_1 ready with address equal to ld_1's address (ready_bus=5'b00101) → mem_tag=9.
